// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI transmit sequencer.
package spi_seq_pkg;

  localparam int BYTE_W   = 8;
  // Master sclk divider; newd must be held at least this long to span an sclk rise.
  localparam int SCLK_DIV = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_START = 3'd2,
    WAIT_END   = 3'd3,
    RESP       = 3'd4
  } state_t;

endpackage

// File: rtl/spi_byte_fifo.sv
// Synchronous byte FIFO with head-of-queue read data and occupancy count.
module spi_byte_fifo #(
  parameter int DEPTH  = 8,
  parameter int BYTE_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [BYTE_W-1:0]      wr_data,
  input  logic                   pop,
  output logic [BYTE_W-1:0]      rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spi_byte_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/spi_tx_sequencer.sv
// Buffers command bytes and issues them one at a time to the byte-wide SPI master.
// Optional echo compare against the issued byte: define SPI_SEQ_ECHO_CHECK_EN.
module spi_tx_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int NEWD_HOLD     = 8,
  parameter int START_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [BYTE_W-1:0]      wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   newd,
  output logic [BYTE_W-1:0]      din,
  input  logic                   cs,
  input  logic [BYTE_W-1:0]      m_dout,
  output logic                   busy,
  output logic                   rsp_valid,
  output logic [BYTE_W-1:0]      rsp_data,
  output logic                   err_timeout,
  output logic                   err_mismatch
);

  localparam int TW = $clog2(START_TIMEOUT) + 1;

  if (NEWD_HOLD < SCLK_DIV || NEWD_HOLD > 16) begin : g_bad_hold
    $error("spi_tx_sequencer: NEWD_HOLD must be within one to two sclk periods");
  end

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        hold_cnt;
  logic [TW-1:0]     to_cnt;
  logic              cs_sync_p0;
  logic              cs_sync_p1;
  logic [BYTE_W-1:0] capture;
  logic [BYTE_W-1:0] cap_nxt;
  logic [BYTE_W-1:0] fifo_rd;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              timeout_hit;

  spi_byte_fifo #(
    .DEPTH  (DEPTH),
    .BYTE_W (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_en),
    .wr_data (wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign newd      = (state == ISSUE);
  assign busy      = (state == ISSUE) || (state == WAIT_START) || (state == WAIT_END);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    cap_nxt     = capture;
    case (state)
      IDLE:       if (!fifo_empty) state_nxt = ISSUE;
      // A cs fall seen during the hold goes straight to WAIT_END once the hold ends.
      ISSUE:      if (hold_cnt == '0) state_nxt = cs_sync_p1 ? WAIT_START : WAIT_END;
      WAIT_START: begin
        if (!cs_sync_p1) begin
          state_nxt = WAIT_END;
        end else if (to_cnt == TW'(START_TIMEOUT - 1)) begin
          state_nxt   = IDLE;
          timeout_hit = 1'b1;
        end
      end
      WAIT_END: begin
        if (m_dout != '0) cap_nxt = m_dout;
        if (cs_sync_p1) state_nxt = RESP;
      end
      RESP:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_p0  <= 1'b1;
      cs_sync_p1  <= 1'b1;
      hold_cnt    <= '0;
      to_cnt      <= '0;
      din         <= '0;
      capture     <= '0;
      rsp_data    <= '0;
      err_timeout <= 1'b0;
    end else begin
      cs_sync_p0 <= cs;
      cs_sync_p1 <= cs_sync_p0;
      if (fifo_pop) begin
        din      <= fifo_rd;
        hold_cnt <= 4'(NEWD_HOLD - 1);
        to_cnt   <= '0;
        capture  <= '0;
      end
      if (state == ISSUE && hold_cnt != '0) hold_cnt <= hold_cnt - 4'd1;
      if (state == ISSUE || state == WAIT_START) to_cnt <= to_cnt + TW'(1);
      if (state == WAIT_END) capture <= cap_nxt;
      if (state == WAIT_END && cs_sync_p1) rsp_data <= cap_nxt;
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end

`ifdef SPI_SEQ_ECHO_CHECK_EN
  logic [BYTE_W-1:0] issued;
  logic              mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued   <= '0;
      mismatch <= 1'b0;
    end else begin
      if (fifo_pop) issued <= fifo_rd;
      if (state == RESP && rsp_data != issued) mismatch <= 1'b1;
    end
  end

  assign err_mismatch = mismatch;
`else
  assign err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Directed bench for spi_tx_sequencer with a behavioural SPI master and echoing slave.
module tb_spi_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic [3:0] level;
  logic       newd;
  logic [7:0] din;
  logic       cs;
  logic [7:0] m_dout;
  logic       busy;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       err_timeout;
  logic       err_mismatch;

  logic       master_en = 1'b0;
  logic       remap     = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_tx_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .level        (level),
    .newd         (newd),
    .din          (din),
    .cs           (cs),
    .m_dout       (m_dout),
    .busy         (busy),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .err_timeout  (err_timeout),
    .err_mismatch (err_mismatch)
  );

  function automatic logic [7:0] slave_resp(input logic [7:0] b, input logic rm);
    return (rm && b == 8'hA5) ? 8'h5A : b;
  endfunction

  // Behavioural master: cs low a few clocks after newd, eight sclk periods, then echo.
  initial begin
    logic [7:0] m_sent;
    cs     = 1'b1;
    m_dout = '0;
    forever begin
      @(negedge clk);
      if (newd && master_en) begin
        m_sent = din;
        repeat (3) @(negedge clk);
        cs = 1'b0;
        repeat (64) @(negedge clk);
        m_dout = slave_resp(m_sent, remap);
        cs     = 1'b1;
        @(negedge clk);
        m_dout = '0;
      end
    end
  end

  int         cyc = 0;
  int         rsp_cnt = 0;
  int         dbl_cnt = 0;
  int         newd_run = 0;
  int         newd_len = 0;
  int         newd_rise_cyc = 0;
  int         et_cyc = 0;
  logic       newd_q = 1'b0;
  logic       rsp_q_prev = 1'b0;
  logic       et_q = 1'b0;
  logic [7:0] rsp_q [$];

  always @(negedge clk) begin
    cyc        <= cyc + 1;
    newd_q     <= newd;
    rsp_q_prev <= rsp_valid;
    et_q       <= err_timeout;
    if (newd && !newd_q) begin
      newd_rise_cyc <= cyc;
      newd_run      <= 1;
    end else if (newd) begin
      newd_run <= newd_run + 1;
    end
    if (!newd && newd_q) newd_len <= newd_run;
    if (rsp_valid) begin
      rsp_cnt <= rsp_cnt + 1;
      rsp_q.push_back(rsp_data);
    end
    if (rsp_valid && rsp_q_prev) dbl_cnt <= dbl_cnt + 1;
    if (err_timeout && !et_q) et_cyc <= cyc;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget, input string tag);
    int k = 0;
    while (rsp_cnt < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, rsp_cnt, n);
  endtask

  function automatic logic [7:0] rsp_at(input int i);
    if (i >= 0 && i < rsp_q.size()) return rsp_q[i];
    return 8'hxx;
  endfunction

  initial begin
    int         k;
    int         base;
    logic       exp_mis;
`ifdef SPI_SEQ_ECHO_CHECK_EN
    exp_mis = 1'b1;
`else
    exp_mis = 1'b0;
`endif
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    repeat (3) tick();

    chk("rst_newd", newd, 0);
    chk("rst_din", din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_err_mismatch", err_mismatch, 0);

    rst       = 1'b0;
    master_en = 1'b1;
    tick();

    // Single byte round trip
    push(8'hA5);
    wait_rsp(1, 300, "a5_rsp_wait");
    chk("a5_newd_len", newd_len, 8);
    chk("a5_rsp_data", rsp_at(0), 8'hA5);
    tick();
    chk("a5_busy_after", busy, 0);
    chk("a5_err_mismatch", err_mismatch, 0);
    chk("a5_level", level, 0);

    // Zero byte followed by a burst that fills the FIFO behind it
    push(8'h00);
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk("burst_full", full, 1);
    chk("burst_level", level, 8);
    push(8'hFF);
    chk("burst_drop_level", level, 8);
    wait_rsp(10, 1500, "burst_rsp_wait");
    chk("zero_rsp_data", rsp_at(1), 8'h00);
    for (int i = 1; i <= 8; i++) chk($sformatf("burst_rsp_%0d", i), rsp_at(1 + i), 8'(i));
    repeat (100) tick();
    chk("burst_no_ff", rsp_cnt, 10);
    chk("burst_level_end", level, 0);
    chk("burst_full_end", full, 0);
    chk("rsp_single_cycle", dbl_cnt, 0);

    // Start timeout: master silent, second byte queued behind
    master_en = 1'b0;
    push(8'h3C);
    push(8'h77);
    k = 0;
    while (!err_timeout && k < 200) begin
      tick();
      k++;
    end
    chk("to_err_timeout", err_timeout, 1);
    chk("to_latency", et_cyc - newd_rise_cyc, 64);
    chk("to_busy", busy, 0);
    chk("to_no_rsp", rsp_cnt, 10);
    master_en = 1'b1;
    wait_rsp(11, 300, "to_next_rsp_wait");
    chk("to_next_rsp_data", rsp_at(10), 8'h77);
    chk("to_sticky", err_timeout, 1);

    // Reset while waiting for cs to rise
    push(8'h55);
    k = 0;
    while (!(busy && !newd && !cs) && k < 100) begin
      tick();
      k++;
    end
    chk("mid_wait_end", busy && !newd && !cs, 1);
    push(8'h11);
    push(8'h22);
    chk("mid_level", level, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_newd", newd, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_busy", busy, 0);
    tick();
    rst  = 1'b0;
    base = rsp_cnt;
    repeat (120) tick();
    chk("mid_no_rsp", rsp_cnt, base);
    chk("mid_busy_after", busy, 0);
    chk("mid_level_after", level, 0);
    chk("mid_err_timeout_cleared", err_timeout, 0);

    // Echo mismatch and stickiness
    remap = 1'b1;
    push(8'hA5);
    wait_rsp(base + 1, 300, "mis_rsp_wait");
    chk("mis_rsp_data", rsp_at(base), 8'h5A);
    remap = 1'b0;
    repeat (2) tick();
    chk("mis_flag", err_mismatch, exp_mis);
    push(8'h42);
    wait_rsp(base + 2, 300, "mis_next_rsp_wait");
    chk("mis_next_rsp_data", rsp_at(base + 1), 8'h42);
    repeat (2) tick();
    chk("mis_sticky", err_mismatch, exp_mis);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
